rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port (RFWr/A3/WD) between two requesters: the CPU writeback stage (cpu_*) and the switch-driven debug writer (dbg_*).
- Sits between the requesters and the RF instance in the top level.
- Issues at most one write per cycle, with registered outputs.
- Applies fixed CPU priority with an anti-starvation override, honours a global write-protect, and counts committed writes for display.

---
 rtl/rf_wport_arbiter_if.sv | 28 ++
 rtl/rf_wport_arbiter.sv | 95 +++++++++
 tb/tb_rf_wport_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_if.sv
// Register-file write-port bundle: two requester handshakes plus the arbitrated RF write bus.
// The master side drives requests and observes grants; the slave side is the arbiter.
interface rf_wport_arbiter_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          cpu_gnt;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          dbg_gnt;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    modport master (
        output cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data,
        input  cpu_gnt, dbg_gnt, rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_data, dbg_req, dbg_addr, dbg_data,
        output cpu_gnt, dbg_gnt, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single RF write port between CPU writeback and the debug writer.
// CPU has priority; debug is forced through after STARVE_MAX consecutive CPU wins.
module rf_wport_arbiter #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CW         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wp,
    rf_wport_arbiter_if.slave bus,
    output logic [CW-1:0]     wr_cnt,
    output logic              starve_o
);

    typedef enum logic [1:0] {StIdle, StCpuWr, StDbgWr} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          cpu_el, dbg_el;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: a requester whose grant is currently high sits out this edge.
    always_comb begin
        cpu_el   = bus.cpu_req && (state_q != StCpuWr) && !wp;
        dbg_el   = bus.dbg_req && (state_q != StDbgWr) && !wp;
        state_d  = StIdle;
        starve_d = starve_q;
        if (cpu_el && dbg_el) begin
            if (starve_q == StarveMax) begin
                state_d  = StDbgWr;
                starve_d = '0;
            end else begin
                state_d  = StCpuWr;
                starve_d = starve_q + 4'd1;
            end
        end else if (cpu_el) begin
            state_d = StCpuWr;
        end else if (dbg_el) begin
            state_d  = StDbgWr;
            starve_d = '0;
        end
    end

    // Write datapath; x0 writes handshake but never reach the RF or the counter,
    // and the address/data bus only moves on a committed write.
    always_comb begin
        win_addr = (state_d == StDbgWr) ? bus.dbg_addr : bus.cpu_addr;
        win_data = (state_d == StDbgWr) ? bus.dbg_data : bus.cpu_data;
        we_d     = (state_d != StIdle) && (win_addr != '0);
        wa_d     = we_d ? win_addr : wa_q;
        wd_d     = we_d ? win_data : wd_q;
        cnt_d    = cnt_q + CW'(we_d);
    end

    // Outputs
    always_comb begin
        bus.cpu_gnt = (state_q == StCpuWr);
        bus.dbg_gnt = (state_q == StDbgWr);
        bus.rf_we   = we_q;
        bus.rf_wa   = wa_q;
        bus.rf_wd   = wd_q;
        wr_cnt      = cnt_q;
        starve_o    = (starve_q == StarveMax);
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: expected grants are queued with each stimulus step
// and checked one edge later.
module tb_rf_wport_arbiter;

    typedef struct packed {
        logic        cpu;
        logic        dbg;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wp;
    logic [15:0] wr_cnt;
    logic        starve_o;
    int          n_tests;
    int          n_fail;
    exp_t        sb_q[$];

    rf_wport_arbiter_if #(.AW(5), .DW(32)) bus ();

    rf_wport_arbiter #(
        .AW(5),
        .DW(32),
        .STARVE_MAX(4),
        .CW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wp(wp),
        .bus(bus),
        .wr_cnt(wr_cnt),
        .starve_o(starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Queue the expected grant for the coming edge, then compare once it has happened.
    task automatic cyc(input logic c, input logic d, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
        exp_t e;
        sb_q.push_back('{cpu: c, dbg: d, we: we, wa: wa, wd: wd});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(e.cpu));
        chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(e.dbg));
        chk("rf_we", 32'(bus.rf_we), 32'(e.we));
        if (e.we) begin
            chk("rf_wa", 32'(bus.rf_wa), 32'(e.wa));
            chk("rf_wd", bus.rf_wd, e.wd);
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        wp           = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 5'd5;
        bus.cpu_data = 32'hA5;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 5'd7;
        bus.dbg_data = 32'h77;

        // Reset holds everything at zero despite live requests
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        chk("rst_rf_wd", bus.rf_wd, 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_starve", 32'(starve_o), 32'd0);
        rst = 1'b0;

        // First edge after release: CPU wins, then dbg, then idle with bus held
        cyc(1'b1, 1'b0, 1'b1, 5'd5, 32'hA5);
        chk("first_wr_cnt", 32'(wr_cnt), 32'd1);
        bus.cpu_req = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 5'd7, 32'h77);
        bus.dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("hold_rf_wa", 32'(bus.rf_wa), 32'd7);
        chk("hold_rf_wd", bus.rf_wd, 32'h77);
        chk("wr_cnt_2", 32'(wr_cnt), 32'd2);

        // CPU alone: one grant every second cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 5'd3;
        bus.cpu_data = 32'h12;
        for (int i = 0; i < 8; i++) begin
            cyc((i % 2) == 0, 1'b0, (i % 2) == 0, 5'd3, 32'h12);
        end
        bus.cpu_req = 1'b0;
        chk("cpu_only_wr_cnt", 32'(wr_cnt), 32'd6);

        // Both held: strict alternation, starvation never builds
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 5'd4;
        bus.cpu_data = 32'h44;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 5'd9;
        bus.dbg_data = 32'h99;
        for (int i = 0; i < 6; i++) begin
            if ((i % 2) == 0) cyc(1'b1, 1'b0, 1'b1, 5'd4, 32'h44);
            else cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
            chk("alt_starve", 32'(starve_o), 32'd0);
        end
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("alt_wr_cnt", 32'(wr_cnt), 32'd12);

        // Starvation: dbg loses four contested arbitrations, then is forced through
        bus.cpu_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.dbg_req = 1'b1;
            cyc(1'b1, 1'b0, 1'b1, 5'd4, 32'h44);
            chk("starve_build", 32'(starve_o), 32'(k == 3));
            bus.dbg_req = 1'b0;
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        end
        chk("starve_held", 32'(starve_o), 32'd1);
        bus.dbg_req = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
        chk("starve_cleared", 32'(starve_o), 32'd0);
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("starve_wr_cnt", 32'(wr_cnt), 32'd17);

        // Address 0: handshake completes but nothing is written or counted
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 5'd0;
        bus.dbg_data = 32'hFFFF_FFFF;
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("x0_wr_cnt", 32'(wr_cnt), 32'd17);
        bus.dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Write protect stalls both requesters
        wp           = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 5'd6;
        bus.cpu_data = 32'h66;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 5'd8;
        bus.dbg_data = 32'h88;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        end
        chk("wp_wr_cnt", 32'(wr_cnt), 32'd17);
        wp = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 5'd6, 32'h66);
        chk("wp_release_wr_cnt", 32'(wr_cnt), 32'd18);
        bus.dbg_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 5'd6, 32'h66);

        // Asynchronous reset while cpu_gnt is high
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("arst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("arst_wr_cnt", 32'(wr_cnt), 32'd0);
        #3;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 5'd6, 32'h66);
        chk("post_arst_wr_cnt", 32'(wr_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
